// File: rtl/riscvsoc_gpio.sv
// riscvsoc_gpio -- parametrised bidirectional GPIO port for the riscvsoc
// peripheral bus.
//
// Optional feature macro: RISCVSOC_GPIO_IRQ_EN. When it is defined, this file
// builds the rising-edge interrupt logic: IE, IP, the edge detector, the
// priming counter and irq. When it is undefined, IE and IP read 0, writes to
// them are ignored, and irq is tied to 0.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   addr, wr, rd    register select and one-cycle write/read strobes
//   wdata           write data (bits [WIDTH-1:0] used)
//   rdata           registered read data, zero above WIDTH
//   rdata_valid     one-cycle pulse, the cycle after an accepted rd
//   gpio_in         asynchronous pad inputs
//   gpio_out        pad output values (OUT register)
//   gpio_oe         pad output enables, 1 = drive (DIR register)
//   irq             level interrupt request, registered
//
// Register map: 0 OUT, 1 DIR, 2 IN (read-only), 3 IE, 4 IP (write 1 to
// clear), 5..7 read 0.
module riscvsoc_gpio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] A_OUT = 3'd0;
  localparam logic [2:0] A_DIR = 3'd1;
  localparam logic [2:0] A_IN  = 3'd2;
  localparam logic [2:0] A_IE  = 3'd3;
  localparam logic [2:0] A_IP  = 3'd4;

  logic [WIDTH-1:0] wd;
  logic             unused_wdata;
  assign wd           = wdata[WIDTH-1:0];
  assign unused_wdata = ^wdata;

  // OUT / DIR
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr && addr == A_OUT) out_d = wd;
    if (wr && addr == A_DIR) dir_d = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

  // Input synchroniser. Every pin is sampled whatever its direction, so an
  // output pin reads back its pad value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_val = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0] ie_rd, ip_rd;

`ifdef RISCVSOC_GPIO_IRQ_EN
  localparam int             CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]  PRIME_CNT = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] ie_q, ie_d, ip_q, ip_d, prev_q, edge_set, clr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             primed, irq_q;

  // Edges are not trusted until the synchroniser and prev register have been
  // refilled after reset. Otherwise a pin held high through reset release
  // would look like a fresh rising edge.
  assign primed = (cnt_q == PRIME_CNT);
  assign cnt_d  = primed ? cnt_q : cnt_q + 1'b1;

  assign edge_set = in_val & ~prev_q & ie_q & {WIDTH{primed}};
  assign clr      = (wr && addr == A_IP) ? wd : '0;

  always_comb begin
    ie_d = ie_q;
    if (wr && addr == A_IE) ie_d = wd;
    // A set in the same cycle as a clear wins.
    ip_d = (ip_q & ~clr) | edge_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q   <= '0;
      ip_q   <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      ip_q   <= ip_d;
      prev_q <= in_val;
      cnt_q  <= cnt_d;
      irq_q  <= |(ip_q & ie_q);
    end
  end

  assign ie_rd = ie_q;
  assign ip_rd = ip_q;
  assign irq   = irq_q;
`else
  assign ie_rd = '0;
  assign ip_rd = '0;
  assign irq   = 1'b0;
`endif

  // Read path. The mux sees register values from before this cycle's write,
  // so a read and a write in the same cycle return the pre-write value.
  logic [31:0] rmux;
  logic [31:0] rdata_q, rdata_d;
  logic        rvld_q;

  always_comb begin
    rmux = '0;
    case (addr)
      A_OUT:   rmux[WIDTH-1:0] = out_q;
      A_DIR:   rmux[WIDTH-1:0] = dir_q;
      A_IN:    rmux[WIDTH-1:0] = in_val;
      A_IE:    rmux[WIDTH-1:0] = ie_rd;
      A_IP:    rmux[WIDTH-1:0] = ip_rd;
      default: rmux = '0;
    endcase
    rdata_d = rd ? rmux : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvld_q  <= rd;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;

endmodule

// File: tb/tb_riscvsoc_gpio.sv
module tb_riscvsoc_gpio;
  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   addr;
  logic         wr, rd;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         rdata_valid;
  logic [W-1:0] gpio_in, gpio_out, gpio_oe;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  riscvsoc_gpio #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rdata_valid pulse.
  always @(negedge clk) begin
    if (!rst && rdata_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdata_valid: got rdata 0x%08h expected no pulse", rdata);
      end else begin
        chk(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // All tasks start and end at a negedge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cyc(1);
    wr = 1'b0; wdata = '0;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [31:0] e, input string nm);
    rd = 1'b1; addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0; gpio_in = '0;
    cyc(3);
    chk("reset_oe",     32'(gpio_oe),     32'h0);
    chk("reset_out",    32'(gpio_out),    32'h0);
    chk("reset_irq",    32'(irq),         32'h0);
    chk("reset_rdata",  rdata,            32'h0);
    chk("reset_rvalid", 32'(rdata_valid), 32'h0);
    rst = 1'b0;
    cyc(1);

    // every address reads 0 after reset
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 32'h0, $sformatf("reset_read_%0d", a));

    // DIR / OUT
    wr_reg(3'd1, 32'hF0);
    chk("dir_oe", 32'(gpio_oe), 32'hF0);
    wr_reg(3'd0, 32'hFFFF_FFA5);
    chk("out_pad", 32'(gpio_out), 32'hA5);
    rd_reg(3'd0, 32'h0000_00A5, "read_out");
    rd_reg(3'd1, 32'h0000_00F0, "read_dir");
    cyc(1);
    chk("rdata_hold", rdata, 32'hF0);
    // writes to IN and to 5..7 are ignored
    wr_reg(3'd2, 32'hFF);
    wr_reg(3'd5, 32'hFF);
    rd_reg(3'd2, 32'h0, "read_in_after_write");
    rd_reg(3'd5, 32'h0, "read_5_after_write");
    // same-cycle read and write returns the pre-write value
    rd = 1'b1;
    exp_q.push_back(32'hA5); name_q.push_back("rw_same_cycle");
    wr_reg(3'd0, 32'h5A);
    rd = 1'b0;
    rd_reg(3'd0, 32'h5A, "read_out_after_rw");

    // input synchroniser latency
    gpio_in = 8'h3C;
    for (int k = 0; k <= SS; k++)
      rd_reg(3'd2, (k < SS) ? 32'h0 : 32'h3C, $sformatf("in_latency_%0d", k));
    rd_reg(3'd2, 32'h3C, "in_steady");

    gpio_in = 8'h00;
    cyc(SS + 3);

`ifdef RISCVSOC_GPIO_IRQ_EN
    wr_reg(3'd3, 32'h01);
    rd_reg(3'd3, 32'h01, "read_ie");
    gpio_in = 8'h01;
    for (int k = 1; k <= SS + 2; k++) begin
      cyc(1);
      if (k == SS + 1) chk("irq_before_latency", 32'(irq), 32'h0);
      if (k == SS + 2) chk("irq_at_latency", 32'(irq), 32'h1);
    end
    rd_reg(3'd4, 32'h01, "ip_pin0");
    wr_reg(3'd4, 32'h01);
    chk("irq_one_cycle_after_clear", 32'(irq), 32'h1);
    cyc(1);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd_reg(3'd4, 32'h0, "ip_cleared");
    gpio_in = 8'h03;
    cyc(SS + 3);
    rd_reg(3'd4, 32'h0, "ip_pin1_masked");
    chk("irq_pin1_masked", 32'(irq), 32'h0);
`endif

    // reset mid-operation: outputs clear at once, outstanding read gives no pulse
    gpio_in = 8'hFF;
    rd = 1'b1; addr = 3'd0;
    #1 rst = 1'b1;
    #1;
    chk("midreset_oe", 32'(gpio_oe), 32'h0);
    chk("midreset_out", 32'(gpio_out), 32'h0);
    cyc(2);
    rd = 1'b0;
    cyc(1);
    chk("midreset_rvalid", 32'(rdata_valid), 32'h0);
    rst = 1'b0;
    wr_reg(3'd3, 32'hFF);
    cyc(SS + 4);

`ifdef RISCVSOC_GPIO_IRQ_EN
    rd_reg(3'd4, 32'h0, "ip_held_high_through_reset");
    chk("irq_held_high", 32'(irq), 32'h0);
    // pin 3 low, then high with the W1C landing on the edge cycle
    gpio_in = 8'hF7;
    cyc(SS + 2);
    gpio_in = 8'hFF;
    cyc(SS);
    wr_reg(3'd4, 32'h08);
    rd_reg(3'd4, 32'h08, "ip_set_beats_clear");
    wr_reg(3'd4, 32'hFF);
    rd_reg(3'd4, 32'h0, "ip_clear_all");
`else
    rd_reg(3'd3, 32'h0, "ie_reads_zero");
    gpio_in = 8'h00;
    cyc(SS + 3);
    gpio_in = 8'hFF;
    cyc(SS + 3);
    chk("irq_tied_low", 32'(irq), 32'h0);
    rd_reg(3'd4, 32'h0, "ip_reads_zero");
    rd_reg(3'd2, 32'hFF, "in_still_synced");
`endif

    cyc(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscvsoc_gpio.md
# riscvsoc_gpio

Parametrised GPIO port controller for the riscvsoc SoC, replacing the fixed 8-bit LED output with a WIDTH-bit bidirectional port. Each pin has a direction bit, a registered output and a synchronised input. Optional rising-edge interrupt logic raises `irq` to the core. It sits on the SoC peripheral bus and drives `gpio_port` pads through the board top level.

## Interface
- `WIDTH`, 8, number of GPIO pins; legal 1..32
- `SYNC_STAGES`, 2, input synchroniser depth; legal 2..4
- `clk`  in  1  system clock (100 MHz in the current build)
- `rst`  in  1  reset; asynchronous, active-high
- `addr`  in  3  register select
- `wr`  in  1  write strobe, one cycle per access
- `rd`  in  1  read strobe, one cycle per access
- `wdata`  in  32  write data; bits [WIDTH-1:0] used
- `rdata`  out  32  registered read data; bits above WIDTH are 0
- `rdata_valid`  out  1  high exactly one cycle after an accepted `rd`
- `gpio_in`  in  WIDTH  pad inputs, asynchronous to `clk`
- `gpio_out`  out  WIDTH  pad output values
- `gpio_oe`  out  WIDTH  pad output enables, 1 = drive
- `irq`  out  1  level interrupt request

## Operation
- Register map, by `addr`:
  - 0 OUT: read/write.
  - 1 DIR: read/write; 1 = output.
  - 2 IN: read-only; the synchronised pin value.
  - 3 IE: read/write; rising-edge interrupt enable.
  - 4 IP: interrupt pending; write-1-to-clear.
  - 5..7: read 0; writes are ignored.
- Writes to IN are ignored.
- `gpio_out` = OUT. `gpio_oe` = DIR. Both are driven directly from the registers.
- IN is sampled from all pins regardless of DIR, so output pins read back their pad value.
- Input path: `gpio_in` passes through a SYNC_STAGES flip-flop chain, then through one further `prev` register used for edge detection.
- Rising edge on pin i: synchronised bit = 1 and `prev` bit = 0, while the primed flag is set. When IE[i]=1, this sets IP[i].
- Edges on pins with IE[i]=0 are not recorded.
- Priming counter:
  - Cleared by reset.
  - Counts up to SYNC_STAGES+1, then sets `primed` and holds.
  - Edges are ignored until `primed` is set. A pin held high through reset release therefore raises no interrupt.
- IP update per cycle: IP_next = (IP & ~(wr at addr 4 ? wdata : 0)) | edge_set. A set in the same cycle as a clear wins.
- `irq` = |(IP & IE), registered.
- `wr` and `rd` asserted in the same cycle: the write takes effect, and the read returns the pre-write value.
- Reset mid-operation clears everything immediately. An outstanding read produces no `rdata_valid`.

## Timing
- Reset values:
  - OUT, DIR, IE, IP: 0.
  - Synchroniser, `prev`, `primed`, counter: 0.
  - `rdata`: 0; `rdata_valid`: 0; `irq`: 0.
  - `gpio_out`: 0; `gpio_oe`: 0, so all pins are inputs.
- Write latency: a register write at edge N is visible on its outputs after edge N.
- Read latency: `rd` sampled at edge N gives `rdata` and `rdata_valid` valid after edge N. `rdata` holds until the next read.
- Input latency: a `gpio_in` change is visible in IN SYNC_STAGES cycles after the first sampling edge.
- IP is set 1 cycle after that, and `irq` rises 1 cycle after IP. The total is SYNC_STAGES+2 cycles from pad to `irq`.
- Back-to-back accesses are allowed every cycle. There is no wait state.

## Configuration
- Macro `RISCVSOC_GPIO_IRQ_EN`.
- Defined: IE, IP, the edge detector, the priming counter and `irq` are built as described above.
- Undefined:
  - IE and IP read 0; writes to them are ignored.
  - `irq` is tied to 0.
  - Edge logic and the priming counter are not instantiated.
  - The IN path is still SYNC_STAGES deep.

## Test plan
- Reset, then read all addresses 0..7 → every `rdata`=0. `gpio_oe`=0, `gpio_out`=0, `irq`=0.
- WIDTH=8: write DIR=0xF0, then OUT=0xA5 → `gpio_oe`=0xF0 and `gpio_out`=0xA5 on the cycle after each write. Read OUT → `rdata`=0x000000A5 with `rdata_valid` pulsed once.
- Drive `gpio_in`=0x3C → reading IN before SYNC_STAGES cycles returns the old value, and from SYNC_STAGES cycles on returns 0x3C.
- IE=0x01; pin 0 rises 0→1 → IP=0x01, and `irq`=1 at SYNC_STAGES+2 cycles. Write 0x01 to IP → IP=0 and `irq` falls next cycle. Pin 1 edge with IE[1]=0 → IP stays 0.
- Hold `gpio_in`=0xFF across reset release with IE=0xFF → IP stays 0. Toggle pin 3 low then high during a W1C write of 0x08 in the same cycle as the edge → IP[3]=1.
- Macro undefined: IE=0xFF, toggle all pins → `irq` stays 0, and IE/IP read 0.
